// File: rtl/pe_pkg.sv
// Shared definitions for the convolution processing element: derived widths,
// the per-beat control word that travels down the pipeline, and the
// requantisation helper that the pooling unit also reuses.
package pe_pkg;

   // Width used inside the requantiser; wide enough for any PW up to 64.
   localparam int REQ_W = 64;

   // Control fields captured together with a beat's data.
   typedef struct packed {
      logic       acc_en;
      logic       acc_first;
      logic       acc_last;
      logic       relu_en;
      logic       quan_en;
      logic [4:0] qshift;
   } ctrl_t;

   // Full-precision width of one tap product: (DW+1)-bit activation times WW-bit weight.
   function automatic int f_prod_w(input int dw, input int ww);
      return dw + ww + 1;
   endfunction

   // Number of first-level group adders: ceil(taps / group).
   function automatic int f_ngrp(input int taps, input int group);
      return (taps + group - 1) / group;
   endfunction

   // Round-half-up right shift followed by saturation into [0, 2^ow-1].
   // Negative results always clamp to 0, never wrap to the maximum.
   function automatic logic [REQ_W-1:0] f_requant(input logic signed [REQ_W-1:0] r,
                                                  input logic [4:0]              qshift,
                                                  input int                      ow);
      logic signed [REQ_W-1:0] t;
      logic signed [REQ_W-1:0] max_v;
      logic                    round_bit;
      round_bit = r[{1'b0, qshift - 5'd1}];
      if (qshift == 5'd0) begin
         t = r;
      end else begin
         t = (r >>> qshift) + $signed({{(REQ_W-1){1'b0}}, round_bit});
      end
      max_v = (64'sd1 <<< ow) - 64'sd1;
      if (t < 64'sd0) begin
         return '0;
      end else if (t > max_v) begin
         return max_v;
      end else begin
         return t;
      end
   endfunction

endpackage

// File: rtl/pe_group_adder.sv
// N-input adder with a registered result; used as the first-level partial
// adder over one group of tap products. Sums wrap modulo 2^W.
module pe_group_adder #(
   parameter int N = 13,
   parameter int W = 32
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           en,
   input  logic [N*W-1:0] in_data,
   output logic [W-1:0]   sum
);

   logic [W-1:0] sum_s;

   // Combinational sum of all N inputs (two's complement wrap).
   always_comb begin
      sum_s = '0;
      for (int i = 0; i < N; i++) begin
         sum_s = sum_s + in_data[i*W +: W];
      end
   end

   // Result register; holds while the pipeline is stalled.
   always_ff @(posedge clk) begin
      if (rst) begin
         sum <= '0;
      end else if (en) begin
         sum <= sum_s;
      end
   end

endmodule

// File: rtl/pe_mac_pipe.sv
// Convolution processing element: TAPS-tap multiply-accumulate, partial-sum or
// cross-channel accumulation, optional ReLU and requantisation. Four-stage
// pipeline that advances as a single unit under downstream back-pressure.
module pe_mac_pipe
   import pe_pkg::*;
#(
   parameter int TAPS      = 25,
   parameter int DW        = 8,
   parameter int WW        = 8,
   parameter int IF_SIGNED = 0,
   parameter int PW        = 32,
   parameter int OW        = 8,
   parameter int GROUP     = 13
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [TAPS*DW-1:0] in_if,
   input  logic [TAPS*WW-1:0] in_w,
   input  logic [PW-1:0]      psum,
   input  logic               acc_en,
   input  logic               acc_first,
   input  logic               acc_last,
   input  logic               relu_en,
   input  logic               quan_en,
   input  logic [4:0]         qshift,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [PW-1:0]      pe_out
);

   localparam int PRODW = f_prod_w(DW, WW);
   localparam int NGRP  = f_ngrp(TAPS, GROUP);

   logic adv;
   logic take;
   ctrl_t in_ctrl;

   // The whole pipeline moves together whenever the output slot is free or drained.
   assign adv      = out_ready | ~out_valid;
   assign in_ready = adv;
   assign take     = in_valid & adv;
   assign in_ctrl  = {acc_en, acc_first, acc_last, relu_en, quan_en, qshift};

   // ---------------- S1: tap products ----------------
   logic [TAPS*PW-1:0] mul_s;
   logic [TAPS*PW-1:0] mul_r;
   logic               v1_r;
   ctrl_t              ctrl1_r;
   logic [PW-1:0]      psum1_r;

   // Per-tap product: activation extended by one bit (sign or zero), weight signed.
   always_comb begin
      logic signed [DW:0]      a_ext;
      logic signed [WW-1:0]    w_v;
      logic signed [PRODW-1:0] p_v;
      mul_s = '0;
      a_ext = '0;
      w_v   = '0;
      p_v   = '0;
      for (int i = 0; i < TAPS; i++) begin
         if (IF_SIGNED != 0) begin
            a_ext = {in_if[i*DW+DW-1], in_if[i*DW +: DW]};
         end else begin
            a_ext = {1'b0, in_if[i*DW +: DW]};
         end
         w_v = in_w[i*WW +: WW];
         p_v = a_ext * w_v;
         mul_s[i*PW +: PW] = PW'(p_v);
      end
   end

   // S1 register: products, control word and partial sum captured with the beat.
   always_ff @(posedge clk) begin
      if (rst) begin
         v1_r    <= 1'b0;
         mul_r   <= '0;
         ctrl1_r <= '0;
         psum1_r <= '0;
      end else if (adv) begin
         v1_r    <= take;
         mul_r   <= mul_s;
         ctrl1_r <= in_ctrl;
         psum1_r <= psum;
      end
   end

   // ---------------- S2: group sums ----------------
   logic [NGRP*PW-1:0] grp_r;
   logic               v2_r;
   ctrl_t              ctrl2_r;
   logic [PW-1:0]      psum2_r;

   for (genvar g = 0; g < NGRP; g++) begin : g_grp
      localparam int LO = g * GROUP;
      localparam int HI = ((g + 1) * GROUP < TAPS) ? (g + 1) * GROUP : TAPS;
      pe_group_adder #(
         .N (HI - LO),
         .W (PW)
      ) u_add (
         .clk     (clk),
         .rst     (rst),
         .en      (adv),
         .in_data (mul_r[LO*PW +: (HI-LO)*PW]),
         .sum     (grp_r[g*PW +: PW])
      );
   end

   // S2 sideband register keeping valid/control/psum aligned with the group sums.
   always_ff @(posedge clk) begin
      if (rst) begin
         v2_r    <= 1'b0;
         ctrl2_r <= '0;
         psum2_r <= '0;
      end else if (adv) begin
         v2_r    <= v1_r;
         ctrl2_r <= ctrl1_r;
         psum2_r <= psum1_r;
      end
   end

   // ---------------- S3: total, psum / accumulator ----------------
   logic [PW-1:0] total_s;
   logic [PW-1:0] base_s;
   logic [PW-1:0] new_s;
   logic          s3_vld_s;
   logic [PW-1:0] acc_r;
   logic [PW-1:0] s3_r;
   logic          v3_r;
   logic          relu3_r;
   logic          quan3_r;
   logic [4:0]    qsh3_r;

   // Window total plus either the external psum (plain or first beat) or the running accumulator.
   always_comb begin
      total_s = '0;
      for (int g = 0; g < NGRP; g++) begin
         total_s = total_s + grp_r[g*PW +: PW];
      end
      if (ctrl2_r.acc_en & ~ctrl2_r.acc_first) begin
         base_s = acc_r;
      end else begin
         base_s = psum2_r;
      end
      new_s    = total_s + base_s;
      s3_vld_s = v2_r & (~ctrl2_r.acc_en | ctrl2_r.acc_last);
   end

   // S3 register and cross-channel accumulator; non-last accumulation beats leave an empty slot.
   always_ff @(posedge clk) begin
      if (rst) begin
         acc_r   <= '0;
         s3_r    <= '0;
         v3_r    <= 1'b0;
         relu3_r <= 1'b0;
         quan3_r <= 1'b0;
         qsh3_r  <= 5'd0;
      end else if (adv) begin
         v3_r    <= s3_vld_s;
         s3_r    <= new_s;
         relu3_r <= ctrl2_r.relu_en;
         quan3_r <= ctrl2_r.quan_en;
         qsh3_r  <= ctrl2_r.qshift;
         if (v2_r & ctrl2_r.acc_en) begin
            acc_r <= new_s;
         end
      end
   end

   // ---------------- S4: ReLU / requantise, output register ----------------
   logic [PW-1:0] relu_s;
   logic [PW-1:0] out_s;

   // Optional ReLU, then either full precision or the rounded, saturated OW-bit value.
   always_comb begin
      if (relu3_r & s3_r[PW-1]) begin
         relu_s = '0;
      end else begin
         relu_s = s3_r;
      end
      if (quan3_r) begin
         out_s = PW'(f_requant(REQ_W'($signed(relu_s)), qsh3_r, OW));
      end else begin
         out_s = relu_s;
      end
   end

   // Output register; holds value and valid while downstream stalls.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         pe_out    <= '0;
      end else if (adv) begin
         out_valid <= v3_r;
         pe_out    <= out_s;
      end
   end

endmodule

// File: tb/tb_pe_mac_pipe.sv
// Self-checking bench for pe_mac_pipe: table of single-beat vectors, hand
// accumulation / reset sequences and randomised traffic under back-pressure,
// all checked against an arithmetic reference model.
module tb_pe_mac_pipe;

   localparam int TAPS = 25;
   localparam int DW   = 8;
   localparam int WW   = 8;
   localparam int PW   = 32;
   localparam int OW   = 8;

   logic               clk;
   logic               rst;
   logic               in_valid;
   logic               in_ready;
   logic [TAPS*DW-1:0] in_if;
   logic [TAPS*WW-1:0] in_w;
   logic [PW-1:0]      psum;
   logic               acc_en, acc_first, acc_last, relu_en, quan_en;
   logic [4:0]         qshift;
   logic               out_valid;
   logic               out_ready;
   logic [PW-1:0]      pe_out;

   pe_mac_pipe #(
      .TAPS(TAPS), .DW(DW), .WW(WW), .IF_SIGNED(0), .PW(PW), .OW(OW), .GROUP(13)
   ) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_if(in_if), .in_w(in_w), .psum(psum), .acc_en(acc_en),
      .acc_first(acc_first), .acc_last(acc_last), .relu_en(relu_en),
      .quan_en(quan_en), .qshift(qshift), .out_valid(out_valid),
      .out_ready(out_ready), .pe_out(pe_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [TAPS*DW-1:0] ifv;
      logic [TAPS*WW-1:0] w;
      logic [31:0]        ps;
      bit                 acc_en, acc_first, acc_last, relu, quan;
      bit [4:0]           qs;
   } beat_t;

   typedef struct {
      int          a;
      int          w;
      int          ps;
      bit          relu;
      bit          quan;
      int          qs;
      logic [31:0] exp;
   } vec_t;

   beat_t       pend[$];
   logic [31:0] expq[$];
   int          exp_cyc[$];
   logic [31:0] outs[$];
   int          errors = 0;
   int          checks = 0;
   int          cyc = 0;
   int          n_out = 0;
   logic [31:0] last_out = 32'd0;
   bit          rnd_ready = 1'b0;
   bit          lat_chk = 1'b0;
   longint      acc_m = 0;
   bit          prev_stall = 1'b0;
   logic [31:0] prev_val = 32'd0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
      end
   endtask

   // Reference: dot product with plain integer arithmetic (activations unsigned).
   function automatic longint model_total(input beat_t b);
      longint tot = 0;
      for (int i = 0; i < TAPS; i++) begin
         tot += longint'(int'(b.ifv[i*DW +: DW])) * longint'(int'($signed(b.w[i*WW +: WW])));
      end
      return tot;
   endfunction

   // Reference: ReLU then round-half-up division by 2^q and clamp into [0,255].
   function automatic logic [31:0] model_post(input int s, input bit relu, input bit quan, input int q);
      longint r;
      longint t;
      r = s;
      if (relu && r < 0) r = 0;
      if (!quan) return r[31:0];
      if (q == 0) t = r;
      else t = (r + (longint'(1) <<< (q - 1))) >>> q;
      if (t < 0) t = 0;
      if (t > 255) t = 255;
      return t[31:0];
   endfunction

   task automatic model_accept(input beat_t b);
      longint tot;
      int     s;
      bit     prod;
      tot = model_total(b);
      if (!b.acc_en) begin
         s = int'(tot + longint'($signed(b.ps)));
         prod = 1'b1;
      end else begin
         if (b.acc_first) acc_m = tot + longint'($signed(b.ps));
         else acc_m = acc_m + tot;
         acc_m = longint'(int'(acc_m));
         s = int'(acc_m);
         prod = b.acc_last;
      end
      if (prod) begin
         expq.push_back(model_post(s, b.relu, b.quan, int'(b.qs)));
         exp_cyc.push_back(cyc);
      end
   endtask

   function automatic beat_t mk_uni(input int a, input int w, input int ps,
                                    input bit relu, input bit quan, input int qs);
      beat_t b;
      for (int i = 0; i < TAPS; i++) begin
         b.ifv[i*DW +: DW] = a[7:0];
         b.w[i*WW +: WW]   = w[7:0];
      end
      b.ps = ps; b.relu = relu; b.quan = quan; b.qs = qs[4:0];
      b.acc_en = 1'b0; b.acc_first = 1'b0; b.acc_last = 1'b0;
      return b;
   endfunction

   // Accumulation beat whose window total is a*w carried on tap 0 only.
   function automatic beat_t mk_acc(input int a, input int w, input int ps,
                                    input bit first, input bit last);
      beat_t b;
      b = mk_uni(0, 0, ps, 1'b0, 1'b0, 0);
      b.ifv[7:0] = a[7:0];
      b.w[7:0]   = w[7:0];
      b.acc_en = 1'b1; b.acc_first = first; b.acc_last = last;
      return b;
   endfunction

   // One clock: drive inputs at the falling edge, then check and score outputs.
   task automatic cycle();
      int c;
      @(negedge clk);
      cyc++;
      out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (pend.size() > 0) begin
         in_valid  = 1'b1;
         in_if     = pend[0].ifv;
         in_w      = pend[0].w;
         psum      = pend[0].ps;
         acc_en    = pend[0].acc_en;
         acc_first = pend[0].acc_first;
         acc_last  = pend[0].acc_last;
         relu_en   = pend[0].relu;
         quan_en   = pend[0].quan;
         qshift    = pend[0].qs;
      end else begin
         in_valid  = 1'b0;
         acc_en    = 1'($urandom_range(0, 1));
         acc_first = 1'($urandom_range(0, 1));
      end
      #1;
      chk("in_ready", {31'd0, in_ready}, {31'd0, !(out_valid && !out_ready)});
      if (prev_stall) begin
         chk("hold_valid", {31'd0, out_valid}, 32'd1);
         chk("hold_data", pe_out, prev_val);
      end
      prev_stall = out_valid && !out_ready;
      prev_val   = pe_out;
      if (out_valid && out_ready) begin
         n_out++;
         last_out = pe_out;
         outs.push_back(pe_out);
         if (expq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL spurious_out: got 0x%08h expected no output", pe_out);
         end else begin
            chk("pe_out", pe_out, expq.pop_front());
            c = exp_cyc.pop_front();
            if (lat_chk) chk("latency", cyc - c, 32'd4);
         end
      end
      if (in_valid && in_ready) model_accept(pend.pop_front());
   endtask

   task automatic drain(input int bound);
      for (int k = 0; k < bound && (pend.size() > 0 || expq.size() > 0); k++) cycle();
      if (pend.size() > 0 || expq.size() > 0) begin
         checks++;
         errors++;
         $display("FAIL drain_timeout: got %0d pending beats %0d pending results expected 0",
                  pend.size(), expq.size());
         pend.delete();
         expq.delete();
         exp_cyc.delete();
      end
      repeat (6) cycle();
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      #1;
      chk("rst_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_data", pe_out, 32'd0);
      rst = 1'b0;
      pend.delete();
      expq.delete();
      exp_cyc.delete();
      acc_m = 0;
      prev_stall = 1'b0;
   endtask

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation exceeded its time limit");
      $fatal(1);
   end

   initial begin
      vec_t  tbl[12];
      beat_t b;
      int    n0;
      int    rl;

      tbl[0]  = '{a:2,   w:3,   ps:10,         relu:0, quan:0, qs:0, exp:32'd160};
      tbl[1]  = '{a:255, w:-1,  ps:0,          relu:0, quan:0, qs:0, exp:32'hFFFFE719};
      tbl[2]  = '{a:255, w:-1,  ps:0,          relu:1, quan:1, qs:0, exp:32'd0};
      tbl[3]  = '{a:0,   w:0,   ps:191,        relu:0, quan:1, qs:7, exp:32'd1};
      tbl[4]  = '{a:0,   w:0,   ps:192,        relu:0, quan:1, qs:7, exp:32'd2};
      tbl[5]  = '{a:0,   w:0,   ps:40000,      relu:0, quan:1, qs:7, exp:32'd255};
      tbl[6]  = '{a:0,   w:0,   ps:200,        relu:0, quan:1, qs:0, exp:32'd200};
      tbl[7]  = '{a:0,   w:0,   ps:-300,       relu:0, quan:1, qs:3, exp:32'd0};
      tbl[8]  = '{a:255, w:-1,  ps:0,          relu:1, quan:0, qs:0, exp:32'd0};
      tbl[9]  = '{a:0,   w:0,   ps:-5,         relu:0, quan:0, qs:0, exp:32'hFFFFFFFB};
      tbl[10] = '{a:1,   w:1,   ps:32'h7FFFFFF0, relu:0, quan:0, qs:0, exp:32'h80000009};
      tbl[11] = '{a:3,   w:-2,  ps:1000,       relu:0, quan:1, qs:2, exp:32'd213};

      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      in_if = '0; in_w = '0; psum = '0;
      acc_en = 1'b0; acc_first = 1'b0; acc_last = 1'b0;
      relu_en = 1'b0; quan_en = 1'b0; qshift = 5'd0;
      repeat (3) @(negedge clk);
      #1;
      chk("reset_valid", {31'd0, out_valid}, 32'd0);
      chk("reset_data", pe_out, 32'd0);
      chk("reset_ready", {31'd0, in_ready}, 32'd1);
      rst = 1'b0;

      // Table of single beats, each with its own fixed expected result and latency 4.
      lat_chk = 1'b1;
      for (int i = 0; i < 12; i++) begin
         n0 = n_out;
         pend.push_back(mk_uni(tbl[i].a, tbl[i].w, tbl[i].ps, tbl[i].relu, tbl[i].quan, tbl[i].qs));
         drain(20);
         chk("table_count", n_out - n0, 32'd1);
         chk("table_value", last_out, tbl[i].exp);
      end

      // Accumulation run 100+5, +200, -50, then a back-to-back fresh single-beat run of 7.
      n0 = n_out;
      outs.delete();
      pend.push_back(mk_acc(100, 1, 5, 1'b1, 1'b0));
      pend.push_back(mk_acc(200, 1, 0, 1'b0, 1'b0));
      pend.push_back(mk_acc(50, -1, 0, 1'b0, 1'b1));
      pend.push_back(mk_acc(7, 1, 0, 1'b1, 1'b1));
      drain(30);
      chk("acc_count", n_out - n0, 32'd2);
      if (outs.size() >= 2) begin
         chk("acc_run1", outs[0], 32'd255);
         chk("acc_run2", outs[1], 32'd7);
      end

      // Reset after two of four accumulation beats; new single-beat run returns only its total.
      pend.push_back(mk_acc(10, 1, 3, 1'b1, 1'b0));
      pend.push_back(mk_acc(20, 1, 0, 1'b0, 1'b0));
      pend.push_back(mk_acc(30, 1, 0, 1'b0, 1'b0));
      pend.push_back(mk_acc(40, 1, 0, 1'b0, 1'b1));
      for (int k = 0; k < 20 && pend.size() > 2; k++) cycle();
      do_reset();
      n0 = n_out;
      pend.push_back(mk_acc(9, 1, 0, 1'b1, 1'b1));
      drain(20);
      chk("rst_run_count", n_out - n0, 32'd1);
      chk("rst_run_value", last_out, 32'd9);

      // Non-first beat with no prior run accumulates onto zero.
      do_reset();
      n0 = n_out;
      pend.push_back(mk_acc(11, 1, 1000, 1'b0, 1'b1));
      drain(20);
      chk("nofirst_count", n_out - n0, 32'd1);
      chk("nofirst_value", last_out, 32'd11);

      // Back-pressure stream of 8 beats followed by randomised traffic.
      lat_chk = 1'b0;
      rnd_ready = 1'b1;
      n0 = n_out;
      for (int i = 0; i < 8; i++) begin
         pend.push_back(mk_uni(i + 1, 2 - i, 100 * i, 1'b0, 1'b0, 0));
      end
      drain(200);
      chk("bp_count", n_out - n0, 32'd8);

      for (int i = 0; i < 40; i++) begin
         rl = (($urandom_range(0, 2) == 0)) ? 0 : int'($urandom_range(1, 4));
         for (int j = 0; j < ((rl == 0) ? 1 : rl); j++) begin
            for (int t = 0; t < TAPS; t++) begin
               b.ifv[t*DW +: DW] = 8'($urandom);
               b.w[t*WW +: WW]   = 8'($urandom);
            end
            b.ps   = $urandom;
            b.relu = 1'($urandom_range(0, 1));
            b.quan = 1'($urandom_range(0, 1));
            b.qs   = 5'($urandom_range(0, 31));
            b.acc_en    = (rl != 0);
            b.acc_first = (rl != 0) && (j == 0);
            b.acc_last  = (rl != 0) && (j == rl - 1);
            pend.push_back(b);
         end
      end
      drain(2000);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/pe_mac_pipe.md
Name: pe_mac_pipe

Overview:
- Parametrised convolution processing element: TAPS-tap multiply-accumulate over one activation window and one weight window.
- Adds an external partial sum or an internal cross-channel accumulator, then applies optional ReLU and requantisation.
- Valid/ready streaming with back-pressure; fixed 4-cycle latency when not stalled.
- Sits in the PE array between the line-buffer/window generator and the output SRAM writer. Successor to the fixed 25-tap, 8-bit PE.

Parameters:
- TAPS, 25, number of taps (K*K); range 1..64.
- DW, 8, activation width.
- WW, 8, weight width; weights always signed.
- IF_SIGNED, 0, 1 = activations signed; 0 = unsigned, zero-extended by one bit.
- PW, 32, partial-sum, accumulator and full-precision output width.
- OW, 8, quantised output width, unsigned.
- GROUP, 13, taps per first-level partial adder; NGRP = ceil(TAPS/GROUP).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  PE accepts a beat this cycle.
- in_if  in  TAPS*DW  activations; tap i is bits [i*DW +: DW].
- in_w  in  TAPS*WW  weights; same packing as in_if.
- psum  in  PW  signed external partial sum for this beat.
- acc_en  in  1  accumulate mode: use the internal accumulator instead of psum.
- acc_first  in  1  first beat of an accumulation run.
- acc_last  in  1  last beat of an accumulation run; an output is produced only on this beat.
- relu_en  in  1  clamp negative results to 0.
- quan_en  in  1  emit the requantised value.
- qshift  in  5  right-shift amount for requantisation, 0..31.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- pe_out  out  PW  result; when quan_en=1, upper PW-OW bits are 0.

Behaviour:
- Reset: clears all pipeline valid bits, the accumulator and all datapath registers. out_valid=0, pe_out=0.
- Advance: adv = out_ready | ~out_valid; in_ready = adv.
  - When adv=0 every stage holds, the accumulator included. The whole pipeline moves as one.
  - A beat is taken when in_valid & in_ready.
- Control capture: acc_en, acc_first, acc_last, relu_en, quan_en and qshift are captured with the data and travel with it. Changing them mid-flight never affects beats already accepted.
- S1: registers mul[i] = ext(in_if_i) * in_w_i, full product width DW+WW+1, sign-extended to PW.
- S2: registers NGRP group sums. Group g covers taps g*GROUP .. min((g+1)*GROUP, TAPS)-1.
- S3: total = sum of groups.
  - acc_en=0: s3 = total + psum.
  - acc_en=1 with acc_first: acc <= total + psum.
  - acc_en=1 without acc_first: acc <= acc + total.
  - s3 valid only if acc_en=0 or acc_last=1; when s3 is valid in acc mode, s3 = the new acc value.
  - acc_first & acc_last together is a single-beat run.
  - All sums wrap modulo 2^PW (two's complement, no saturation).
- S4 (output register):
  - r = (relu_en & s3<0) ? 0 : s3.
  - quan_en=0: pe_out = r.
  - quan_en=1:
    - t = (qshift==0) ? r : (r >>> qshift) + r[qshift-1], i.e. round half up.
    - t<0 gives 0; t > 2^OW-1 gives 2^OW-1; otherwise t.
    - Negative values saturate to 0, never to max.
- Latency: accepted beat to out_valid is 4 advancing cycles.
- Output hold: pe_out and out_valid hold while out_valid & ~out_ready.
- No-output beats: in acc mode, non-last beats produce no out_valid bubble-free; the slot is simply empty.
- Reset mid-run: discards the partial accumulation and all in-flight beats; the next run must start with acc_first.
- Error case: acc_en=1 without acc_first and with no prior run accumulates onto the reset value 0. This is defined behaviour, not an error.

Decomposition:
- Shared package pe_pkg:
  - localparams for product width (DW+WW+1) and NGRP computation.
  - Function f_requant(r, qshift, OW) holding the round/saturate logic, reused by the pooling unit.
- One natural sub-module: pe_group_adder (parametrised N-input signed adder, registered output), instantiated NGRP times.

Test Plan:
- Basic window: TAPS=25; all in_if=2, in_w=3, psum=10, relu/quan off. Required: pe_out=160 four cycles after accept, out_valid one cycle.
- Sign, ReLU, quantise: in_w=-1, in_if=255 on all taps, psum=0.
  - relu_en=0: pe_out = -6375 (0xFFFFE719).
  - relu_en=1, quan_en=1: pe_out=0.
- Requantisation rounding: sum 191, qshift=7, quan_en=1 gives 1; sum 192 gives 2; sum 40000 gives 255; qshift=0 with sum 200 gives 200.
- Accumulation run: 3 beats, acc_en=1, totals 100, 200, -50, psum=5 on the first beat.
  - Required: exactly one out_valid, pe_out=255.
  - Back-to-back second run with acc_first starts fresh.
- Back-pressure: stream 8 beats with out_ready toggling 1,0,0,1 pseudo-randomly. Required: no loss or duplication, results in order, pe_out stable while stalled, in_ready = ~(out_valid & ~out_ready).
- Reset mid-run: rst for 1 cycle after 2 of 4 accumulation beats. Required: out_valid=0 and pe_out=0 the next cycle; a new single-beat run returns only its own total.
